traffic_light_fsm: RTL

TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

---
 rtl/traffic_pkg.sv | 47 ++++
 rtl/request_latch.sv | 17 +
 rtl/traffic_light_fsm.sv | 106 ++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light controller:
// state encodings, per-state durations and lamp patterns.
package traffic_pkg;

  typedef enum logic [3:0] {
    INIT        = 4'd0,
    MAIN_G      = 4'd1,
    MAIN_Y      = 4'd2,
    RED_TO_SIDE = 4'd3,
    SIDE_G      = 4'd4,
    SIDE_Y      = 4'd5,
    WALK        = 4'd6,
    WALK_BLINK  = 4'd7,
    RED_TO_MAIN = 4'd8
  } state_t;

  localparam logic [3:0] DUR_MAIN_G      = 4'd8;
  localparam logic [3:0] DUR_MAIN_Y      = 4'd2;
  localparam logic [3:0] DUR_RED_TO_SIDE = 4'd1;
  localparam logic [3:0] DUR_SIDE_G      = 4'd5;
  localparam logic [3:0] DUR_SIDE_Y      = 4'd2;
  localparam logic [3:0] DUR_WALK        = 4'd4;
  localparam logic [3:0] DUR_WALK_BLINK  = 4'd3;
  localparam logic [3:0] DUR_RED_TO_MAIN = 4'd1;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  function automatic logic [3:0] dur(input state_t s);
    logic [3:0] d;
    d = 4'd0;
    unique case (s)
      MAIN_G:      d = DUR_MAIN_G;
      MAIN_Y:      d = DUR_MAIN_Y;
      RED_TO_SIDE: d = DUR_RED_TO_SIDE;
      SIDE_G:      d = DUR_SIDE_G;
      SIDE_Y:      d = DUR_SIDE_Y;
      WALK:        d = DUR_WALK;
      WALK_BLINK:  d = DUR_WALK_BLINK;
      RED_TO_MAIN: d = DUR_RED_TO_MAIN;
      default:     d = 4'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/request_latch.sv
// Sticky request flag: set by a level input, cleared by a pulse.
// Clear beats set when both arrive together.
module request_latch (
  input  logic clock,
  input  logic reset,
  input  logic set,
  input  logic clear,
  output logic pend
);

  always_ff @(posedge clock) begin
    if (reset)      pend <= 1'b0;
    else if (clear) pend <= 1'b0;
    else if (set)   pend <= 1'b1;
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// Main/side street controller with pedestrian phase; drives an
// external countdown timer via start_timer/value.
module traffic_light_fsm
  import traffic_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       side_sensor,
  input  logic       walk_btn,
  input  logic       expired,
  input  logic       two_hz_enable,
  output logic       start_timer,
  output logic [3:0] value,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk_lamp,
  output logic [3:0] state_code
);

  state_t     state;
  state_t     state_n;
  logic       fire;
  logic       car_pend;
  logic       walk_pend;
  logic       car_clr;
  logic       walk_clr;
  logic [3:0] value_n;
  logic [2:0] main_n;
  logic [2:0] side_n;
  logic       lamp_n;

  request_latch u_car (
    .clock (clock),
    .reset (reset),
    .set   (side_sensor),
    .clear (car_clr),
    .pend  (car_pend)
  );

  request_latch u_walk (
    .clock (clock),
    .reset (reset),
    .set   (walk_btn),
    .clear (walk_clr),
    .pend  (walk_pend)
  );

  // expired is stale while the timer is being reloaded
  assign fire = (state == INIT) || (expired && !start_timer);

  always_comb begin
    state_n = state;
    if (fire) begin
      unique case (state)
        INIT:        state_n = MAIN_G;
        MAIN_G:      state_n = (car_pend || walk_pend) ? MAIN_Y : MAIN_G;
        MAIN_Y:      state_n = RED_TO_SIDE;
        RED_TO_SIDE: state_n = walk_pend ? WALK : SIDE_G;
        SIDE_G:      state_n = SIDE_Y;
        SIDE_Y:      state_n = RED_TO_MAIN;
        WALK:        state_n = WALK_BLINK;
        WALK_BLINK:  state_n = car_pend ? SIDE_G : RED_TO_MAIN;
        RED_TO_MAIN: state_n = MAIN_G;
        default:     state_n = INIT;
      endcase
    end

    value_n = fire ? dur(state_n) : 4'd0;
    main_n  = RED;
    side_n  = RED;
    lamp_n  = 1'b0;
    unique case (state_n)
      MAIN_G:     main_n = GRN;
      MAIN_Y:     main_n = YEL;
      SIDE_G:     side_n = GRN;
      SIDE_Y:     side_n = YEL;
      WALK:       lamp_n = 1'b1;
      WALK_BLINK: lamp_n = fire ? 1'b1 : (walk_lamp ^ two_hz_enable);
      default:    lamp_n = 1'b0;
    endcase
  end

  assign car_clr  = fire && (state_n == SIDE_G);
  assign walk_clr = fire && (state_n == WALK);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= INIT;
      start_timer <= 1'b0;
      value       <= 4'd0;
      main_lights <= RED;
      side_lights <= RED;
      walk_lamp   <= 1'b0;
    end else begin
      state       <= state_n;
      start_timer <= fire;
      value       <= value_n;
      main_lights <= main_n;
      side_lights <= side_n;
      walk_lamp   <= lamp_n;
    end
  end

  assign state_code = state;

endmodule
